// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl
//   Steers CPU data accesses either to dmem (single-cycle, combinational ack)
//   or to one of four peripheral slots inside a 64-byte window. Each
//   peripheral access is a short transaction: a one-cycle chip-enable pulse,
//   a ready wait bounded by a timeout, then a one-cycle ack to the CPU.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   cpu_req           CPU access request (level, held until cpu_ack)
//   daddr, dwdata, we CPU byte address, write data, byte enables (0 = read)
//   drdata            dmem read data
//   p_rdata, p_ready  per-slot read data (32 bits per slot) and ready strobes
//   cpu_rdata         read data returned to the CPU
//   cpu_ack, cpu_err  access complete / access timed out
//   dmem_we           byte enables forwarded to dmem
//   p_ce              one-hot slot chip enable
//   p_we, p_be        peripheral write strobe and byte enables
//   p_addr, p_wdata   peripheral word select and write data
//   err_count         saturating count of timed-out accesses
//
// state  | meaning
// IDLE   | no peripheral access; dmem path live
// ACCESS | chip-enable pulse to the latched slot
// WAIT   | waiting for ready on the latched slot, timeout counting
// DONE   | ack to CPU with latched data / error
module periph_bus_ctrl #(
  parameter logic [31:0] PBASE    = 32'h0000_0400,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic [31:0]  daddr,
  input  logic [31:0]  dwdata,
  input  logic [3:0]   we,
  input  logic [31:0]  drdata,
  input  logic [127:0] p_rdata,
  input  logic [3:0]   p_ready,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_ack,
  output logic         cpu_err,
  output logic [3:0]   dmem_we,
  output logic [3:0]   p_ce,
  output logic         p_we,
  output logic [3:0]   p_be,
  output logic [1:0]   p_addr,
  output logic [31:0]  p_wdata,
  output logic [7:0]   err_count
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    slot_l;
  logic [1:0]    word_l;
  logic [3:0]    we_l;
  logic [31:0]   wdata_l;
  logic [31:0]   rdata_l;
  logic          err_l;
  logic [CW-1:0] cnt;

  logic          hit;
  logic          ready_sel;
  logic          timeout_hit;
  logic [31:0]   slot_rdata;
  logic          dmem_go;

  // Byte-offset bits and the low bits of the window base play no role in decode.
  logic unused_bits;
  assign unused_bits = ^{daddr[1:0], PBASE[5:0]};

  assign hit         = (daddr[31:6] == PBASE[31:6]);
  assign ready_sel   = p_ready[slot_l];
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
  assign slot_rdata  = p_rdata[{slot_l, 5'b0} +: 32];

  // dmem accesses are only served while no peripheral transaction is in
  // flight; otherwise the CPU simply stalls.
  assign dmem_go = !reset && cpu_req && !hit && (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req && hit) state_nxt = ACCESS;
      ACCESS:  state_nxt = WAIT;
      WAIT:    if (ready_sel || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_l    <= '0;
      word_l    <= '0;
      we_l      <= '0;
      wdata_l   <= '0;
      rdata_l   <= '0;
      err_l     <= 1'b0;
      cnt       <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req && hit) begin
            slot_l  <= daddr[5:4];
            word_l  <= daddr[3:2];
            we_l    <= we;
            wdata_l <= dwdata;
            rdata_l <= '0;
            err_l   <= 1'b0;
            cnt     <= '0;
          end
        end
        WAIT: begin
          if (ready_sel) begin
            rdata_l <= (we_l == 4'b0) ? slot_rdata : 32'h0;
            err_l   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_l <= (we_l == 4'b0) ? ERR_DATA : 32'h0;
            err_l   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (err_l && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Address, data and byte enables are driven straight from the latches so
  // they stay stable through WAIT and read as zero after reset.
  assign p_be    = we_l;
  assign p_addr  = word_l;
  assign p_wdata = wdata_l;

  always_comb begin
    p_ce      = 4'b0;
    p_we      = 1'b0;
    cpu_ack   = 1'b0;
    cpu_err   = 1'b0;
    cpu_rdata = 32'h0;
    dmem_we   = 4'b0;
    if (!reset) begin
      if (dmem_go) begin
        dmem_we   = we;
        cpu_rdata = drdata;
        cpu_ack   = 1'b1;
      end
      case (state)
        ACCESS: begin
          p_ce[slot_l] = 1'b1;
          p_we         = |we_l;
        end
        DONE: begin
          cpu_ack   = 1'b1;
          cpu_err   = err_l;
          cpu_rdata = rdata_l;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_ctrl.sv
module tb_periph_bus_ctrl;

  localparam logic [31:0] PBASE = 32'h0000_0400;

  logic         clk;
  logic         reset;
  logic         cpu_req;
  logic [31:0]  daddr;
  logic [31:0]  dwdata;
  logic [3:0]   we;
  logic [31:0]  drdata;
  logic [127:0] p_rdata;
  logic [3:0]   p_ready;
  logic [31:0]  cpu_rdata;
  logic         cpu_ack;
  logic         cpu_err;
  logic [3:0]   dmem_we;
  logic [3:0]   p_ce;
  logic         p_we;
  logic [3:0]   p_be;
  logic [1:0]   p_addr;
  logic [31:0]  p_wdata;
  logic [7:0]   err_count;

  int errors = 0;
  int checks = 0;

  periph_bus_ctrl dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .daddr(daddr),
    .dwdata(dwdata), .we(we), .drdata(drdata), .p_rdata(p_rdata),
    .p_ready(p_ready), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cpu_err(cpu_err), .dmem_we(dmem_we), .p_ce(p_ce), .p_we(p_we),
    .p_be(p_be), .p_addr(p_addr), .p_wdata(p_wdata), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are then changed 1 ns after the edge and
  // outputs checked 1 ns later, well away from the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_timeout();
    cpu_req = 1'b1; daddr = PBASE + 32'h10; we = 4'h0; p_ready = 4'b0001;
    repeat (18) cyc();
    cpu_req = 1'b0;
    cyc();
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; daddr = 32'h0; dwdata = 32'h0; we = 4'h0;
    drdata = 32'h0; p_rdata = '0; p_ready = 4'h0;
    p_rdata[31:0]   = 32'h1111_0000;
    p_rdata[63:32]  = 32'h2222_0001;
    p_rdata[95:64]  = 32'hCAFE_0001;
    p_rdata[127:96] = 32'h3333_0003;
    cyc(); cyc();
    reset = 1'b0;
    settle();
    chk("rst_ce",     32'(p_ce), 32'h0);
    chk("rst_ack",    32'(cpu_ack), 32'h0);
    chk("rst_err",    32'(cpu_err), 32'h0);
    chk("rst_rdata",  cpu_rdata, 32'h0);
    chk("rst_errcnt", 32'(err_count), 32'h0);
    chk("rst_addr",   32'(p_addr), 32'h0);
    chk("rst_wdata",  p_wdata, 32'h0);
    chk("rst_be",     32'(p_be), 32'h0);
    chk("rst_we",     32'(p_we), 32'h0);

    // dmem access, same-cycle ack
    cpu_req = 1'b1; daddr = 32'h10; we = 4'hF; dwdata = 32'h1234; drdata = 32'h5555_AAAA;
    settle();
    chk("dm_ack",   32'(cpu_ack), 32'h1);
    chk("dm_we",    32'(dmem_we), 32'hF);
    chk("dm_rdata", cpu_rdata, 32'h5555_AAAA);
    chk("dm_ce",    32'(p_ce), 32'h0);
    chk("dm_err",   32'(cpu_err), 32'h0);
    cpu_req = 1'b0;
    cyc();
    chk("dm_idle_ce",  32'(p_ce), 32'h0);
    chk("dm_idle_ack", 32'(cpu_ack), 32'h0);
    chk("dm_idle_we",  32'(dmem_we), 32'h0);

    // window boundaries: one word past the end and one word before the base
    cpu_req = 1'b1; daddr = PBASE + 32'h40; we = 4'h0; drdata = 32'h0000_0040;
    settle();
    chk("edge_hi_ack", 32'(cpu_ack), 32'h1);
    chk("edge_hi_rd",  cpu_rdata, 32'h0000_0040);
    daddr = PBASE - 32'h4; we = 4'h1;
    settle();
    chk("edge_lo_ack", 32'(cpu_ack), 32'h1);
    chk("edge_lo_we",  32'(dmem_we), 32'h1);
    cpu_req = 1'b0; we = 4'h0;
    cyc();
    chk("edge_idle_ce", 32'(p_ce), 32'h0);

    // peripheral read, slot 2 word 1, ready in first WAIT cycle
    cpu_req = 1'b1; daddr = PBASE + 32'h24; we = 4'h0;
    settle();
    chk("rd_c0_ack", 32'(cpu_ack), 32'h0);
    chk("rd_c0_dmw", 32'(dmem_we), 32'h0);
    cyc();
    chk("rd_acc_ce",   32'(p_ce), 32'h4);
    chk("rd_acc_addr", 32'(p_addr), 32'h1);
    chk("rd_acc_pwe",  32'(p_we), 32'h0);
    chk("rd_acc_ack",  32'(cpu_ack), 32'h0);
    cyc();
    chk("rd_wait_ce",  32'(p_ce), 32'h0);
    chk("rd_wait_ack", 32'(cpu_ack), 32'h0);
    p_ready = 4'b0100;
    cyc();
    chk("rd_done_ack",   32'(cpu_ack), 32'h1);
    chk("rd_done_rdata", cpu_rdata, 32'hCAFE_0001);
    chk("rd_done_err",   32'(cpu_err), 32'h0);
    cpu_req = 1'b0; p_ready = 4'h0;
    cyc();
    chk("rd_after_ack", 32'(cpu_ack), 32'h0);
    chk("rd_after_ce",  32'(p_ce), 32'h0);

    // peripheral write, slot 0 word 3, ready after 5 WAIT cycles
    cpu_req = 1'b1; daddr = PBASE + 32'h0C; we = 4'h3; dwdata = 32'h0000_A5A5;
    settle();
    chk("wr_c0_dmw", 32'(dmem_we), 32'h0);
    cyc();
    chk("wr_acc_ce",    32'(p_ce), 32'h1);
    chk("wr_acc_pwe",   32'(p_we), 32'h1);
    chk("wr_acc_be",    32'(p_be), 32'h3);
    chk("wr_acc_addr",  32'(p_addr), 32'h3);
    chk("wr_acc_wdata", p_wdata, 32'h0000_A5A5);
    chk("wr_acc_dmw",   32'(dmem_we), 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("wr_wait_ce",    32'(p_ce), 32'h0);
      chk("wr_wait_wdata", p_wdata, 32'h0000_A5A5);
      chk("wr_wait_be",    32'(p_be), 32'h3);
      chk("wr_wait_ack",   32'(cpu_ack), 32'h0);
      chk("wr_wait_dmw",   32'(dmem_we), 32'h0);
    end
    cyc();
    chk("wr_w6_ack", 32'(cpu_ack), 32'h0);
    p_ready = 4'b0001;
    cyc();
    chk("wr_done_ack",   32'(cpu_ack), 32'h1);
    chk("wr_done_err",   32'(cpu_err), 32'h0);
    chk("wr_done_rdata", cpu_rdata, 32'h0);
    chk("wr_done_dmw",   32'(dmem_we), 32'h0);
    cpu_req = 1'b0; p_ready = 4'h0; we = 4'h0;
    cyc();

    // timeout on slot 1 while slot 0 keeps signalling ready
    cpu_req = 1'b1; daddr = PBASE + 32'h10; we = 4'h0; p_ready = 4'b0001;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      chk("to_noack", 32'(cpu_ack), 32'h0);
    end
    cyc();
    chk("to_ack",   32'(cpu_ack), 32'h1);
    chk("to_err",   32'(cpu_err), 32'h1);
    chk("to_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cpu_req = 1'b0;
    cyc();
    chk("to_errcnt1", 32'(err_count), 32'h1);
    repeat (299) run_timeout();
    p_ready = 4'h0;
    chk("to_errcnt_sat", 32'(err_count), 32'hFF);

    // reset in the second WAIT cycle of a slot 3 read
    cpu_req = 1'b1; daddr = PBASE + 32'h30; we = 4'h0;
    cyc();
    chk("rs_acc_ce", 32'(p_ce), 32'h8);
    cyc();
    cyc();
    reset = 1'b1; cpu_req = 1'b0;
    settle();
    chk("rs_in_ack", 32'(cpu_ack), 32'h0);
    cyc();
    reset = 1'b0;
    settle();
    chk("rs_ce",     32'(p_ce), 32'h0);
    chk("rs_ack",    32'(cpu_ack), 32'h0);
    chk("rs_errcnt", 32'(err_count), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rs_quiet_ack", 32'(cpu_ack), 32'h0);
      chk("rs_quiet_ce",  32'(p_ce), 32'h0);
    end
    cpu_req = 1'b1; daddr = PBASE + 32'h30;
    cyc();
    chk("rs2_acc_ce", 32'(p_ce), 32'h8);
    cyc();
    p_ready = 4'b1000;
    cyc();
    chk("rs2_ack",   32'(cpu_ack), 32'h1);
    chk("rs2_rdata", cpu_rdata, 32'h3333_0003);
    chk("rs2_err",   32'(cpu_err), 32'h0);
    cpu_req = 1'b0; p_ready = 4'h0;
    cyc();

    // back-to-back: request held across ack, address moves to dmem
    cpu_req = 1'b1; daddr = PBASE; we = 4'h0; drdata = 32'h0000_0077;
    cyc();
    chk("bb_acc_ce", 32'(p_ce), 32'h1);
    cyc();
    p_ready = 4'b0001;
    cyc();
    chk("bb_done_ack",   32'(cpu_ack), 32'h1);
    chk("bb_done_rdata", cpu_rdata, 32'h1111_0000);
    daddr = 32'h0000_0100; p_ready = 4'h0;
    settle();
    chk("bb_done_dmw", 32'(dmem_we), 32'h0);
    cyc();
    chk("bb_dm_ack",   32'(cpu_ack), 32'h1);
    chk("bb_dm_rdata", cpu_rdata, 32'h0000_0077);
    chk("bb_dm_ce",    32'(p_ce), 32'h0);
    cyc();
    chk("bb_dm2_ce",   32'(p_ce), 32'h0);
    chk("bb_dm2_ack",  32'(cpu_ack), 32'h1);
    cpu_req = 1'b0;
    cyc();
    chk("bb_end_ack", 32'(cpu_ack), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
